mem_model: RTL and testbench

Main-memory model sitting directly downstream of the memory sequencer: it consumes the single arbitrated query stream (`qry_cmd`/`qry_idx`/`qry_blk`) and produces the `ack` tag and delayed `ans_blk`/`ans_tag` completions that the sequencer fans back out to devices. It provides block-granular storage with a fixed, parameterised response latency and a bounded number of outstanding transactions. Back-pressure is a zero `ack` tag.

---
 rtl/mem_pkg.sv | 19 +
 rtl/mem_delay.sv | 41 ++++
 rtl/mem_model.sv | 77 +++++++
 tb/tb_mem_model.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory sequencer, devices and the main-memory model.
package mem_pkg;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'd0,
    CMD_LOAD  = 2'd1,
    CMD_STORE = 2'd2
  } mem_cmd_e;

  localparam int BLK_W_DEF = 64;
  localparam int TAG_W_DEF = 4;
  localparam int TAG_NONE  = 0;

  // Encoding 3 is reserved and behaves like NONE.
  function automatic logic is_access(input logic [1:0] cmd);
    return (cmd == CMD_LOAD) || (cmd == CMD_STORE);
  endfunction

endpackage

// File: rtl/mem_delay.sv
// Fixed-latency shift pipeline of {tag, blk}; an empty stage carries tag 0.
module mem_delay #(
  parameter int LATENCY = 4,
  parameter int TAG_W   = 4,
  parameter int BLK_W   = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [BLK_W-1:0] in_blk,
  output logic [TAG_W-1:0] out_tag,
  output logic [BLK_W-1:0] out_blk
);

  logic [LATENCY-1:0][TAG_W-1:0] tag_q, tag_d;
  logic [LATENCY-1:0][BLK_W-1:0] blk_q, blk_d;

  always_comb begin
    tag_d[0] = in_tag;
    blk_d[0] = in_blk;
    for (int i = 1; i < LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
      blk_d[i] = blk_q[i-1];
    end
  end

  // Clearing the data as well keeps ans_blk at zero out of reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tag_q <= '0;
      blk_q <= '0;
    end else begin
      tag_q <= tag_d;
      blk_q <= blk_d;
    end
  end

  assign out_tag = tag_q[LATENCY-1];
  assign out_blk = blk_q[LATENCY-1];

endmodule

// File: rtl/mem_model.sv
// Block-granular main memory with fixed completion latency and bounded outstanding queries.
module mem_model
  import mem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int IDX_W   = $clog2(DEPTH),
  parameter int BLK_W   = BLK_W_DEF,
  parameter int TAG_W   = TAG_W_DEF,
  parameter int LATENCY = 4,
  parameter int MAX_OUT = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       qry_cmd,
  input  logic [IDX_W-1:0] qry_idx,
  input  logic [BLK_W-1:0] qry_blk,
  output logic [TAG_W-1:0] ack,
  output logic [BLK_W-1:0] ans_blk,
  output logic [TAG_W-1:0] ans_tag
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);

  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [TAG_W-1:0] next_tag_q, next_tag_d;
  logic             accept, is_store, done;
  logic [TAG_W-1:0] pipe_tag;
  logic [BLK_W-1:0] pipe_blk;
  logic [BLK_W-1:0] mem_q [DEPTH];

  // The slot check uses the registered count, so a completion frees its slot one cycle later.
  always_comb begin
    is_store   = (qry_cmd == CMD_STORE);
    accept     = reset && is_access(qry_cmd) && (out_cnt_q < CNT_W'(MAX_OUT));
    done       = (ans_tag != TAG_W'(TAG_NONE));
    ack        = accept ? next_tag_q : TAG_W'(TAG_NONE);
    pipe_tag   = ack;
    pipe_blk   = '0;
    if (accept) pipe_blk = is_store ? qry_blk : mem_q[qry_idx];

    next_tag_d = next_tag_q;
    if (accept) next_tag_d = (next_tag_q == '1) ? TAG_W'(1) : next_tag_q + TAG_W'(1);

    out_cnt_d  = out_cnt_q;
    if (accept && !done)      out_cnt_d = out_cnt_q + CNT_W'(1);
    else if (!accept && done) out_cnt_d = out_cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_cnt_q  <= '0;
      next_tag_q <= TAG_W'(1);
    end else begin
      out_cnt_q  <= out_cnt_d;
      next_tag_q <= next_tag_d;
    end
  end

  // Contents survive reset; accept is already gated by reset, so no write happens while it is low.
  always_ff @(posedge clock) begin
    if (accept && is_store) mem_q[qry_idx] <= qry_blk;
  end

  mem_delay #(
    .LATENCY (LATENCY),
    .TAG_W   (TAG_W),
    .BLK_W   (BLK_W)
  ) u_delay (
    .clock   (clock),
    .reset   (reset),
    .in_tag  (pipe_tag),
    .in_blk  (pipe_blk),
    .out_tag (ans_tag),
    .out_blk (ans_blk)
  );

endmodule

// File: tb/tb_mem_model.sv
// Scoreboard bench for mem_model: default configuration plus a LATENCY=1, MAX_OUT=1 instance.
module tb_mem_model;

  localparam int L0 = 4;
  localparam int L1 = 1;

  typedef struct {
    logic [3:0]  tag;
    logic [63:0] blk;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  qc0 = 2'd0, qc1 = 2'd0;
  logic [7:0]  qi0 = '0, qi1 = '0;
  logic [63:0] qb0 = '0, qb1 = '0;
  logic [3:0]  ack0, ack1, at0, at1;
  logic [63:0] ab0, ab1;

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_model dut0 (
    .clock(clk), .reset(rst_n), .qry_cmd(qc0), .qry_idx(qi0), .qry_blk(qb0),
    .ack(ack0), .ans_blk(ab0), .ans_tag(at0)
  );

  mem_model #(.LATENCY(L1), .MAX_OUT(1)) dut1 (
    .clock(clk), .reset(rst_n), .qry_cmd(qc1), .qry_idx(qi1), .qry_blk(qb1),
    .ack(ack1), .ans_blk(ab1), .ans_tag(at1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input bit sel, input logic [1:0] cmd, input logic [7:0] idx, input logic [63:0] blk);
    if (sel) begin qc1 = cmd; qi1 = idx; qb1 = blk; end
    else     begin qc0 = cmd; qi0 = idx; qb0 = blk; end
  endtask

  // Hold a query until acked; check tag and number of refused cycles, then queue the completion.
  task automatic send(input bit sel, input logic [1:0] cmd, input logic [7:0] idx, input logic [63:0] blk,
                      input logic [3:0] exp_tag, input logic [63:0] exp_blk, input int exp_wait);
    int waits;
    logic [3:0] a;
    exp_t e;
    waits = 0;
    drive(sel, cmd, idx, blk);
    forever begin
      @(negedge clk);
      a = sel ? ack1 : ack0;
      if (a != 4'd0 || waits >= 50) break;
      waits++;
      @(posedge clk); #1;
    end
    chk(sel ? "ack1" : "ack0", {60'd0, a}, {60'd0, exp_tag});
    chk(sel ? "ack1_wait" : "ack0_wait", 64'(waits), 64'(exp_wait));
    if (a != 4'd0) begin
      e.tag = exp_tag;
      e.blk = exp_blk;
      e.cyc = cyc + (sel ? L1 : L0);
      if (sel) q1.push_back(e); else q0.push_back(e);
    end
    @(posedge clk); #1;
    drive(sel, 2'd0, 8'd0, 64'd0);
  endtask

  task automatic idle(input bit sel, input int n, input logic [1:0] cmd, input logic [7:0] idx, input logic [63:0] blk);
    drive(sel, cmd, idx, blk);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk(sel ? "ack1_idle" : "ack0_idle", {60'd0, sel ? ack1 : ack0}, 64'd0);
      @(posedge clk); #1;
    end
    drive(sel, 2'd0, 8'd0, 64'd0);
  endtask

  // In-flight work is dropped, so the scoreboard is emptied with it.
  task automatic rst_seq(input logic [1:0] cmd, input logic [7:0] idx, input logic [63:0] blk);
    #1 rst_n = 1'b0;
    q0.delete();
    q1.delete();
    drive(1'b0, cmd, idx, blk);
    drive(1'b1, cmd, idx, blk);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_ack0", {60'd0, ack0}, 64'd0);
      chk("rst_ack1", {60'd0, ack1}, 64'd0);
      chk("rst_ans_tag0", {60'd0, at0}, 64'd0);
      chk("rst_ans_blk0", ab0, 64'd0);
      @(posedge clk); #1;
    end
    drive(1'b0, 2'd0, 8'd0, 64'd0);
    drive(1'b1, 2'd0, 8'd0, 64'd0);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin : mon0
    exp_t e;
    if (at0 != 4'd0) begin
      if (q0.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_cpl0: got tag %0h blk %0h want none (cycle %0d)", at0, ab0, cyc);
      end else begin
        e = q0.pop_front();
        chk("cpl0_tag", {60'd0, at0}, {60'd0, e.tag});
        chk("cpl0_blk", ab0, e.blk);
        chk("cpl0_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (at1 != 4'd0) begin
      if (q1.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_cpl1: got tag %0h blk %0h want none (cycle %0d)", at1, ab1, cyc);
      end else begin
        e = q1.pop_front();
        chk("cpl1_tag", {60'd0, at1}, {60'd0, e.tag});
        chk("cpl1_blk", ab1, e.blk);
        chk("cpl1_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    rst_seq(2'd1, 8'd5, 64'd0);

    // STORE then LOAD same index
    send(0, 2'd2, 8'd5, 64'hDEAD, 4'd1, 64'hDEAD, 0);
    send(0, 2'd1, 8'd5, 64'd0,    4'd2, 64'hDEAD, 0);
    idle(0, 6, 2'd0, 8'd0, 64'd0);

    // four back-to-back loads; the fourth waits for the first completion
    rst_seq(2'd0, 8'd0, 64'd0);
    send(0, 2'd1, 8'd5, 64'd0, 4'd1, 64'hDEAD, 0);
    send(0, 2'd1, 8'd5, 64'd0, 4'd2, 64'hDEAD, 0);
    send(0, 2'd1, 8'd5, 64'd0, 4'd3, 64'hDEAD, 0);
    send(0, 2'd1, 8'd5, 64'd0, 4'd4, 64'hDEAD, 2);
    idle(0, 6, 2'd0, 8'd0, 64'd0);

    // tag wrap skips zero
    rst_seq(2'd0, 8'd0, 64'd0);
    for (int i = 1; i <= 16; i++) begin
      send(0, 2'd2, 8'(i), 64'h1000 + 64'(i), (i == 16) ? 4'd1 : 4'(i), 64'h1000 + 64'(i), 0);
      idle(0, 1, 2'd0, 8'd0, 64'd0);
    end
    idle(0, 5, 2'd0, 8'd0, 64'd0);
    send(0, 2'd1, 8'd3, 64'd0, 4'd2, 64'h1003, 0);
    idle(0, 5, 2'd0, 8'd0, 64'd0);

    // reset with two in flight; store during reset must not land
    send(0, 2'd1, 8'd5, 64'd0, 4'd3, 64'hDEAD, 0);
    send(0, 2'd1, 8'd7, 64'd0, 4'd4, 64'h1007, 0);
    rst_seq(2'd2, 8'd9, 64'hBAD);
    idle(0, 6, 2'd0, 8'd0, 64'd0);
    send(0, 2'd1, 8'd7, 64'd0, 4'd1, 64'h1007, 0);
    send(0, 2'd1, 8'd9, 64'd0, 4'd2, 64'h1009, 0);
    idle(0, 5, 2'd0, 8'd0, 64'd0);

    // reserved command is ignored
    idle(0, 2, 2'd3, 8'd7, 64'hBEEF);
    idle(0, 5, 2'd0, 8'd0, 64'd0);
    send(0, 2'd1, 8'd7, 64'd0, 4'd3, 64'h1007, 0);
    idle(0, 5, 2'd0, 8'd0, 64'd0);

    // LATENCY=1, MAX_OUT=1: a held LOAD is accepted every other cycle
    rst_seq(2'd0, 8'd0, 64'd0);
    send(1, 2'd2, 8'd2, 64'h22, 4'd1, 64'h22, 0);
    send(1, 2'd1, 8'd2, 64'd0,  4'd2, 64'h22, 1);
    send(1, 2'd1, 8'd2, 64'd0,  4'd3, 64'h22, 1);
    send(1, 2'd1, 8'd2, 64'd0,  4'd4, 64'h22, 1);
    idle(1, 3, 2'd0, 8'd0, 64'd0);

    chk("pending0", 64'(q0.size()), 64'd0);
    chk("pending1", 64'(q1.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
